// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for one ECC_CPU core.
// Owns the PC, issues one tagged read at a time on the shared memory bus,
// hands fetched words to decode and follows store-stage redirects.
module fetch_stage #(
  parameter logic [7:0]  core_id  = 8'd0,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic [7:0]  mem_req_core_id,
  input  logic        mem_rsp_valid,
  input  logic [7:0]  mem_rsp_core_id,
  input  logic [31:0] mem_rsp_data,
  input  logic        st_redirect_valid,
  input  logic [63:0] st_redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [63:0] dec_pc,
  output logic [31:0] dec_insn,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [63:0] dec_pc_q, dec_pc_d;
  logic [31:0] dec_insn_q, dec_insn_d;
  logic        rsp_match_s;

  // Only responses tagged with this core's id belong to us.
  assign rsp_match_s = mem_rsp_valid && (mem_rsp_core_id == core_id);

  // Next-state logic: redirect outranks every other event in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    stall_count_d = stall_count_q;
    dec_pc_d      = dec_pc_q;
    dec_insn_d    = dec_insn_q;
    case (state_q)
      ST_REQ: begin
        if (st_redirect_valid) begin
          pc_d = st_redirect_pc;
          if (mem_req_ready) begin
            // The accepted request fetches the stale PC; drop its response.
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end else if (mem_req_ready) begin
          state_d   = ST_WAIT;
          discard_d = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        // Every waiting cycle counts, including ones whose response is dropped.
        stall_count_d = stall_count_q + 32'd1;
        if (st_redirect_valid) begin
          pc_d = st_redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (rsp_match_s) begin
          discard_d = 1'b0;
          if (discard_q || st_redirect_valid) begin
            state_d = ST_REQ;
          end else begin
            dec_pc_d   = pc_q;
            dec_insn_d = mem_rsp_data;
            state_d    = ST_DELIVER;
          end
        end else if (st_redirect_valid) begin
          discard_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DELIVER: begin
        if (st_redirect_valid) begin
          // A coincident decode handshake still completes; decode squashes it.
          pc_d    = st_redirect_pc;
          state_d = ST_REQ;
        end else if (dec_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DELIVER;
        end
      end
      default: begin
        state_d   = ST_REQ;
        discard_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      stall_count_q <= 32'd0;
      dec_pc_q      <= 64'd0;
      dec_insn_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      stall_count_q <= stall_count_d;
      dec_pc_q      <= dec_pc_d;
      dec_insn_q    <= dec_insn_d;
    end
  end

  // Outputs come straight from registered state only.
  assign mem_req_valid   = (state_q == ST_REQ);
  assign mem_req_addr    = pc_q;
  assign mem_req_core_id = core_id;
  assign dec_valid       = (state_q == ST_DELIVER);
  assign dec_pc          = dec_pc_q;
  assign dec_insn        = dec_insn_q;
  assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level model (outstanding
// fetch, pending delivery, next PC) is compared against the DUT every cycle,
// with directed scenarios followed by randomized traffic.
module tb_fetch_stage;

  localparam logic [7:0]  CID = 8'd3;
  localparam logic [63:0] RPC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_core_id;
  logic        mem_rsp_valid;
  logic [7:0]  mem_rsp_core_id;
  logic [31:0] mem_rsp_data;
  logic        st_redirect_valid;
  logic [63:0] st_redirect_pc;
  logic        dec_valid, dec_ready;
  logic [63:0] dec_pc;
  logic [31:0] dec_insn;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  fetch_stage #(.core_id(CID), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_core_id(mem_req_core_id),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_core_id(mem_rsp_core_id),
    .mem_rsp_data(mem_rsp_data),
    .st_redirect_valid(st_redirect_valid), .st_redirect_pc(st_redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_insn(dec_insn), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level model
  logic [63:0] m_pc;          // address of the next instruction to fetch
  bit          m_out;         // a request is accepted and awaiting its response
  bit          m_kill;        // the outstanding fetch was overtaken by a redirect
  logic [63:0] m_fetch_addr;  // address of the outstanding fetch
  bit          m_pend;        // a fetched word is waiting for decode
  logic [63:0] m_dec_pc;
  logic [31:0] m_dec_insn;
  logic [31:0] m_stall;

  // Memory responder and handshake log
  logic [63:0] mq_addr[$];
  int          mq_wait[$];
  bit          mem_fixed;
  logic [63:0] hs_pc[$];
  logic [31:0] hs_insn[$];
  int          hs_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_out = 1'b0; m_kill = 1'b0; m_pend = 1'b0;
    m_fetch_addr = 64'd0; m_dec_pc = 64'd0; m_dec_insn = 32'd0; m_stall = 32'd0;
    mq_addr.delete(); mq_wait.delete();
  endtask

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic model_update();
    bit rd, match;
    rd    = st_redirect_valid;
    match = mem_rsp_valid && (mem_rsp_core_id == CID);
    if (m_out) begin
      m_stall = m_stall + 32'd1;
      if (match) begin
        m_out = 1'b0;
        if (!m_kill && !rd) begin
          m_pend = 1'b1; m_dec_pc = m_fetch_addr; m_dec_insn = mem_rsp_data;
        end
        m_kill = 1'b0;
      end else if (rd) begin
        m_kill = 1'b1;
      end
    end else if (m_pend) begin
      if (dec_ready) begin
        hs_pc.push_back(m_dec_pc); hs_insn.push_back(m_dec_insn); hs_cyc.push_back(cyc);
      end
      if (rd) m_pend = 1'b0;
      else if (dec_ready) begin
        m_pend = 1'b0; m_pc = m_dec_pc + 64'd4;
      end
    end else if (mem_req_ready) begin
      m_out = 1'b1; m_fetch_addr = m_pc; m_kill = rd;
      mq_addr.push_back(m_pc);
      mq_wait.push_back(mem_fixed ? 0 : int'($urandom_range(0, 3)));
    end
    if (rd) m_pc = st_redirect_pc;
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !m_out && !m_pend;
    chk("mem_req_valid", mem_req_valid, exp_req);
    if (exp_req) chk("mem_req_addr", mem_req_addr, m_pc);
    chk("mem_req_core_id", mem_req_core_id, CID);
    chk("dec_valid", dec_valid, m_pend);
    chk("dec_pc", dec_pc, m_dec_pc);
    chk("dec_insn", dec_insn, m_dec_insn);
    chk("stall_count", stall_count, m_stall);
  endtask

  // One clock: inputs already applied, sample results on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst_n) model_update();
    compare();
  endtask

  // Memory bus: answers accepted requests after a delay, injects noise.
  task automatic drive_auto();
    mem_rsp_valid = 1'b0; mem_rsp_core_id = CID; mem_rsp_data = $urandom;
    if (mq_addr.size() > 0) begin
      if (mq_wait[0] == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mq_addr[0][31:0] ^ 32'hA5A5_0000;
        void'(mq_addr.pop_front()); void'(mq_wait.pop_front());
      end else begin
        mq_wait[0] = mq_wait[0] - 1;
        if (!mem_fixed && $urandom_range(0, 2) == 0) begin
          mem_rsp_valid = 1'b1; mem_rsp_core_id = CID + 8'd1;
        end
      end
    end else if (!mem_fixed && $urandom_range(0, 7) == 0) begin
      mem_rsp_valid = 1'b1;  // nothing outstanding: must be ignored
    end
  endtask

  task automatic idle_inputs();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_core_id = CID;
    mem_rsp_data = 32'd0; st_redirect_valid = 1'b0; st_redirect_pc = 64'd0;
    dec_ready = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must react before any clock edge.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", mem_req_valid, 1'b1);
    chk("rst_req_addr", mem_req_addr, RPC);
    chk("rst_req_core_id", mem_req_core_id, CID);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_dec_insn", dec_insn, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    mem_fixed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare();

    // Free-running memory, decode always ready.
    mem_req_ready = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 60 && hs_pc.size() < 4; i++) begin
      drive_auto();
      step();
    end
    chk("t1_handshakes", hs_pc.size(), 64'd4);
    if (hs_pc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_pc", hs_pc[k], 64'(4 * k));
        chk("t1_insn", hs_insn[k], 32'hA5A5_0000 ^ 32'(4 * k));
        if (k > 0) chk("t1_spacing", 64'(hs_cyc[k] - hs_cyc[k-1]), 64'd3);
      end
      chk("t1_stall", stall_count, 32'd4);
    end

    // Decode back-pressure for 5 cycles while delivering.
    dec_ready = 1'b0;
    for (int i = 0; i < 20 && !m_pend; i++) begin
      drive_auto();
      step();
    end
    chk("t2_pending", m_pend, 1'b1);
    begin
      logic [63:0] cap_pc;
      logic [31:0] cap_insn;
      cap_pc = m_dec_pc; cap_insn = m_dec_insn;
      for (int i = 0; i < 5; i++) begin
        drive_auto();
        step();
        chk("t2_dec_valid", dec_valid, 1'b1);
        chk("t2_dec_pc", dec_pc, cap_pc);
        chk("t2_dec_insn", dec_insn, cap_insn);
        chk("t2_no_req", mem_req_valid, 1'b0);
      end
    end
    dec_ready = 1'b1;
    drive_auto();
    step();

    // Request back-pressure and a foreign-tagged response.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_req_held", mem_req_valid, 1'b1);
      chk("t3_addr_held", mem_req_addr, 64'h0);
    end
    mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_core_id = CID + 8'd1; mem_rsp_data = 32'h1234_5678;
    step();
    chk("t3_foreign_ignored", dec_valid, 1'b0);
    chk("t3_stall1", stall_count, 32'd1);
    mem_rsp_core_id = CID; mem_rsp_data = 32'hA5A5_0000;
    step();
    chk("t3_dec_valid", dec_valid, 1'b1);
    chk("t3_dec_pc", dec_pc, 64'h0);
    chk("t3_dec_insn", dec_insn, 32'hA5A5_0000);
    chk("t3_stall2", stall_count, 32'd2);
    mem_rsp_valid = 1'b0; dec_ready = 1'b1;
    step();
    chk("t3_next_addr", mem_req_addr, 64'h4);

    // Redirect to 0x1000 while waiting for a response.
    dec_ready = 1'b0; mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    st_redirect_valid = 1'b1; st_redirect_pc = 64'h1000;
    step();
    st_redirect_valid = 1'b0;
    chk("t4_still_waiting", mem_req_valid, 1'b0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_0004;
    step();
    chk("t4_dropped", dec_valid, 1'b0);
    chk("t4_req_valid", mem_req_valid, 1'b1);
    chk("t4_req_addr", mem_req_addr, 64'h1000);
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_1000;
    step();
    mem_rsp_valid = 1'b0;
    chk("t4_dec_pc", dec_pc, 64'h1000);
    chk("t4_dec_insn", dec_insn, 32'hA5A5_1000);
    chk("t4_stall", stall_count, 32'd5);

    // Redirect to 8 during DELIVER, then redirect 0x2000 with handshake at 8.
    st_redirect_valid = 1'b1; st_redirect_pc = 64'h8;
    step();
    st_redirect_valid = 1'b0;
    chk("t5_drop_valid", dec_valid, 1'b0);
    chk("t5_addr8", mem_req_addr, 64'h8);
    mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_0008;
    step();
    mem_rsp_valid = 1'b0;
    chk("t5_dec_pc8", dec_pc, 64'h8);
    dec_ready = 1'b1; st_redirect_valid = 1'b1; st_redirect_pc = 64'h2000;
    step();
    dec_ready = 1'b0; st_redirect_valid = 1'b0;
    chk("t5_req_valid", mem_req_valid, 1'b1);
    chk("t5_req_addr", mem_req_addr, 64'h2000);

    // Reset while delivering, then a stale response must be ignored.
    mem_req_ready = 1'b1; step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5_2000;
    step();
    mem_rsp_valid = 1'b0;
    chk("t6_delivering", dec_valid, 1'b1);
    apply_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    step();
    chk("t6_stale_ignored", dec_valid, 1'b0);
    chk("t6_restart_addr", mem_req_addr, RPC);
    chk("t6_stall", stall_count, 32'd0);

    // Randomized traffic with redirects, noise and occasional resets.
    apply_reset();
    mem_fixed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
      end else begin
        dec_ready         = ($urandom_range(0, 9) < 7);
        mem_req_ready     = ($urandom_range(0, 9) < 7);
        st_redirect_valid = ($urandom_range(0, 11) == 0);
        st_redirect_pc    = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) st_redirect_pc[1:0] = 2'b00;
        drive_auto();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
